// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port Memoria between instruction fetch (F)
// and data load/store (D). Only one access is in flight at a time. Byte and
// halfword stores are done as read-modify-write of the containing word.
// D is preferred, but after MAX_D_STREAK back-to-back D grants with F waiting,
// F is forced through.
// Optional feature macro: ALIGN_CHK_EN. When it is defined, misaligned word and
// half D accesses complete at once with d_err and never touch memory. When it is
// undefined, the offending low address bits are forced to zero instead.
module mem_port_arbiter #(
  parameter int MEM_RD_LAT   = 1,
  parameter int MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_valid,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic        busy
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_WAIT = 3'd1;
  localparam logic [2:0] RMW_RD  = 3'd2;
  localparam logic [2:0] RMW_WR  = 3'd3;
  localparam logic [2:0] WR      = 3'd4;

  localparam logic [1:0] LAT_LOAD   = 2'(MEM_RD_LAT - 1);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  logic [2:0]  state;
  logic [1:0]  lat_cnt;
  logic [3:0]  streak;
  logic        owner_d;
  logic [1:0]  lat_size;
  logic [1:0]  lat_lo;
  logic [15:0] lat_wdata;

  logic        idle;
  logic        f_wins;
  logic        misalign;
  logic        d_subword;
  logic [31:0] d_eff_addr;

  // Replace one byte or halfword lane of a word; other bits are kept.
  function automatic logic [31:0] merge_lane(input logic [31:0] old_word,
                                             input logic [15:0] wd,
                                             input logic [1:0]  size,
                                             input logic [1:0]  lo);
    logic [31:0] w;
    w = old_word;
    case (size)
      2'b10: w[{lo, 3'b000} +: 8] = wd[7:0];
      2'b01: begin
        if (lo[1]) w[31:16] = wd;
        else       w[15:0]  = wd;
      end
      default: w = old_word;
    endcase
    return w;
  endfunction

  // Grants are combinational so the requester sees acceptance in the same cycle.
  // Reset is folded in so that every output reads 0 while it is held.
  assign idle      = (state == IDLE) && !rst;
  assign f_wins    = f_req && (!d_req || (streak == STREAK_MAX));
  assign f_gnt     = idle && f_wins;
  assign d_gnt     = idle && d_req && !f_wins;
  assign d_subword = (d_size == 2'b01) || (d_size == 2'b10);

  // Word and half accesses use the naturally aligned address.
  always_comb begin
    case (d_size)
      2'b01:   d_eff_addr = {d_addr[31:1], 1'b0};
      2'b10:   d_eff_addr = d_addr;
      default: d_eff_addr = {d_addr[31:2], 2'b00};
    endcase
  end

`ifdef ALIGN_CHK_EN
  // Flag word or half D accesses that are not naturally aligned.
  always_comb begin
    case (d_size)
      2'b01:   misalign = d_addr[0];
      2'b10:   misalign = 1'b0;
      default: misalign = (d_addr[1:0] != 2'b00);
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // Streak of D grants taken while F waits; it saturates and releases F.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= 4'd0;
    end else if (f_gnt) begin
      streak <= 4'd0;
    end else if (d_gnt) begin
      if (!f_req)                    streak <= 4'd0;
      else if (streak != STREAK_MAX) streak <= streak + 4'd1;
      else                           streak <= streak;
    end else begin
      streak <= streak;
    end
  end

  // Sequencer: latches the winner in IDLE and walks it through its memory cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      lat_cnt   <= 2'd0;
      owner_d   <= 1'b0;
      lat_size  <= 2'd0;
      lat_lo    <= 2'd0;
      lat_wdata <= 16'd0;
      mem_addr  <= 32'd0;
      mem_wr    <= 1'b0;
      mem_din   <= 32'd0;
      f_valid   <= 1'b0;
      f_rdata   <= 32'd0;
      d_valid   <= 1'b0;
      d_rdata   <= 32'd0;
      d_err     <= 1'b0;
    end else begin
      f_valid <= 1'b0;
      d_valid <= 1'b0;
      d_err   <= 1'b0;
      case (state)
        IDLE: begin
          mem_wr <= 1'b0;
          if (f_gnt) begin
            owner_d  <= 1'b0;
            mem_addr <= f_addr;
            lat_cnt  <= LAT_LOAD;
            state    <= RD_WAIT;
            busy     <= 1'b1;
          end else if (d_gnt) begin
            owner_d   <= 1'b1;
            lat_size  <= d_size;
            lat_lo    <= d_addr[1:0];
            lat_wdata <= d_wdata[15:0];
            if (misalign) begin
              d_valid <= 1'b1;
              d_err   <= 1'b1;
            end else if (!d_we) begin
              mem_addr <= d_eff_addr;
              lat_cnt  <= LAT_LOAD;
              state    <= RD_WAIT;
              busy     <= 1'b1;
            end else if (d_subword) begin
              mem_addr <= {d_addr[31:2], 2'b00};
              lat_cnt  <= LAT_LOAD;
              state    <= RMW_RD;
              busy     <= 1'b1;
            end else begin
              mem_addr <= d_eff_addr;
              mem_din  <= d_wdata;
              mem_wr   <= 1'b1;
              state    <= WR;
              busy     <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        RD_WAIT: begin
          if (lat_cnt == 2'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (owner_d) begin
              d_valid <= 1'b1;
              d_rdata <= mem_dout;
            end else begin
              f_valid <= 1'b1;
              f_rdata <= mem_dout;
            end
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        RMW_RD: begin
          if (lat_cnt == 2'd0) begin
            mem_din <= merge_lane(mem_dout, lat_wdata, lat_size, lat_lo);
            mem_wr  <= 1'b1;
            state   <= RMW_WR;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        RMW_WR, WR: begin
          mem_wr  <= 1'b0;
          d_valid <= 1'b1;
          state   <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          mem_wr <= 1'b0;
          state  <= IDLE;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the CPU's single-port Memoria between two requesters: instruction fetch (F) and data load/store (D).
- Sequences each access and returns read data with a completion pulse.
- Performs read-modify-write (RMW) for byte and halfword stores, replacing the combinational store-merge mux.
- Sits between the control FSM/datapath and Memoria.

Parameters:
- MEM_RD_LAT, 1: cycles from address applied (mem_wr=0) to mem_dout valid; legal range 1..3.
- MAX_D_STREAK, 4: consecutive D grants allowed while f_req is pending before F is forced a grant; legal range 1..15.

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high
- f_req  in  1  fetch request; held until f_gnt
- f_addr  in  32  fetch byte address
- f_gnt  out  1  1-cycle pulse: fetch accepted this cycle
- f_valid  out  1  1-cycle pulse: f_rdata valid
- f_rdata  out  32  fetched word; holds until next f_valid
- d_req  in  1  data request; held with all d_* fields until d_gnt
- d_we  in  1  1=store, 0=load
- d_size  in  2  00 word, 01 halfword, 10 byte, 11 reserved (treated as word)
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, right-justified for sub-word stores
- d_gnt  out  1  1-cycle pulse: data request accepted
- d_valid  out  1  1-cycle pulse: load data valid or store complete
- d_rdata  out  32  full aligned word read; holds until next load d_valid
- d_err  out  1  alignment error, pulses with d_valid (ALIGN_CHK_EN only)
- mem_addr  out  32  to Memoria Address
- mem_wr  out  1  to Memoria Wr
- mem_din  out  32  to Memoria DataIn
- mem_dout  in  32  from Memoria DataOut
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, any state):
  - state=IDLE.
  - All outputs 0, including mem_addr, mem_din, f_rdata and d_rdata.
  - Streak counter=0.
  - In-flight access aborted; an RMW never issues its write.
- Grants are combinational from state==IDLE and the request lines. Acceptance occurs at the cycle-T edge; the winner's fields are latched.
- Arbitration in IDLE:
  - D wins over F, unless streak==MAX_D_STREAK and f_req=1, in which case F wins.
  - Streak counter increments on each D grant while f_req=1.
  - Streak counter clears on any F grant, or on a D grant with f_req=0.
  - Saturates at MAX_D_STREAK.
- States: IDLE, RD_WAIT, RMW_RD, RMW_WR, WR.
- Fetch, or D load:
  - IDLE -> RD_WAIT for MEM_RD_LAT cycles (T+1..T+MEM_RD_LAT), mem_addr=latched addr, mem_wr=0.
  - mem_dout sampled at end of T+MEM_RD_LAT.
  - f_valid/d_valid=1 at T+MEM_RD_LAT+1, with state back in IDLE.
- Word store:
  - IDLE -> WR at T+1: mem_wr=1, mem_din=d_wdata.
  - d_valid at T+2.
- Sub-word store (RMW):
  - RMW_RD for MEM_RD_LAT cycles, mem_addr={addr[31:2],2'b00}.
  - RMW_WR for 1 cycle, mem_wr=1. mem_din = read word with the target lane replaced:
    - byte: lane addr[1:0], bits [8k+7:8k] <- d_wdata[7:0]
    - half: lane addr[1], bits [16h+15:16h] <- d_wdata[15:0]
    - all other bits unchanged
  - d_valid at T+MEM_RD_LAT+2.
- Outside a write state, mem_wr=0 and mem_din holds its last value.
- Completion and re-grant: the IDLE cycle in which valid pulses may grant a new request, giving back-to-back throughput. At most one access is in flight.
- mem_addr in IDLE holds its last value.
- A request deasserted before its grant is dropped with no side effects.

Optional Feature:
- Macro ALIGN_CHK_EN.
- Defined:
  - A D access with d_size=word and addr[1:0]!=0, or d_size=half and addr[0]!=0, is granted, but no memory cycle is issued.
  - d_valid=1 and d_err=1 at T+1; d_rdata unchanged.
  - Fetches are never checked.
- Undefined:
  - d_err is tied 0.
  - Misaligned word/half accesses force the offending low address bits to 0 and proceed normally.

Test Plan:
- Reset mid-RMW: byte store issued, Reset asserted during RMW_RD -> all outputs 0 immediately, mem_wr never 1, busy=0.
- Fetch of 0x0000_0008, mem word 0x8C22_0004, MEM_RD_LAT=1 -> f_gnt at T, mem_addr=8 at T+1, f_valid with f_rdata=0x8C22_0004 at T+2.
- Byte store d_addr=0x0000_0011, d_wdata=0x0000_00AB, mem[0x10]=0x1122_3344 -> mem_wr at T+2, mem_din=0x1122_AB44, d_valid at T+3.
- Half store d_addr=0x12, d_wdata=0xFFFF_BEEF onto 0x1122_3344 -> mem_din=0xBEEF_3344.
- f_req and d_req held high continuously, MAX_D_STREAK=4 -> 4 D grants, 1 F grant, repeating; F never waits more than 4 D accesses.
- ALIGN_CHK_EN defined, word load d_addr=0x0000_0006 -> d_valid=1, d_err=1 at T+1, mem_wr=0, no RD_WAIT entered; macro undefined -> reads address 0x4, d_err=0.
